// File: rtl/lcd_de_receiver.sv
// DE-only RGB LCD sink: rebuilds pixel coordinates and frame/line markers from DE,
// measures line/frame geometry and declares lock once the geometry repeats.
module lcd_de_receiver #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned VBLANK_MIN  = 2047
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic        lcd_de,
  input  logic [23:0] lcd_rgb,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        sof,
  output logic        eol,
  output logic [10:0] h_disp_meas,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_disp_meas,
  output logic        locked,
  output logic        fmt_err
);
  localparam logic [10:0] CMAX   = '1;
  localparam logic [10:0] VB_MIN = 11'(VBLANK_MIN);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VBLANK, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic        de_q, de_p_q;
  logic [23:0] rgb_q;
  logic [10:0] low_q, low_d, per_q, per_d, x_q, x_d, y_q, y_d;
  logic [10:0] h0_q, h0_d;
  logic        h0_set_q, h0_set_d;
  logic [10:0] hdisp_q, hdisp_d, htot_q, htot_d, vdisp_q, vdisp_d;
  logic [10:0] prev_h_q, prev_h_d, prev_t_q, prev_t_d, prev_v_q, prev_v_d;
  logic        have_prev_q, have_prev_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d, lock_inc;
  logic        locked_q, locked_d, err_seen_q, err_seen_d, fmt_err_q, fmt_err_d;
  logic        valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic [23:0] data_q, data_d;
  logic        rise, fall, vblank, mismatch, sat_hit, same_geom;
  logic [10:0] run, v_lines, thr;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CMAX) ? v : v + 11'd1;
  endfunction

  always_comb begin
    rise      = de_q & ~de_p_q;
    fall      = ~de_q & de_p_q;
    thr       = (htot_q != '0) ? htot_q : VB_MIN;
    vblank    = ~de_q && (low_q >= thr);
    low_d     = de_q ? '0 : sat_inc(low_q);
    per_d     = rise ? 11'd1 : sat_inc(per_q);
    run       = sat_inc(x_q);
    v_lines   = sat_inc(y_q);
    lock_inc  = (lock_cnt_q >= LOCK_N) ? LOCK_N : lock_cnt_q + 4'd1;
    same_geom = have_prev_q && (h0_q == prev_h_q) && (htot_q == prev_t_q) &&
                (v_lines == prev_v_q);

    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    h0_d        = h0_q;
    h0_set_d    = h0_set_q;
    hdisp_d     = hdisp_q;
    htot_d      = htot_q;
    vdisp_d     = vdisp_q;
    prev_h_d    = prev_h_q;
    prev_t_d    = prev_t_q;
    prev_v_d    = prev_v_q;
    have_prev_d = have_prev_q;
    lock_cnt_d  = lock_cnt_q;
    locked_d    = locked_q;
    err_seen_d  = err_seen_q;
    fmt_err_d   = 1'b0;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    data_d      = '0;
    mismatch    = 1'b0;
    sat_hit     = 1'b0;

    case (state_q)
      SEARCH: if (vblank) state_d = VBLANK;
      VBLANK: if (de_q) begin
        state_d    = ACTIVE;
        valid_d    = 1'b1;
        sof_d      = 1'b1;
        eol_d      = ~lcd_de;
        data_d     = rgb_q;
        x_d        = '0;
        y_d        = '0;
        h0_set_d   = 1'b0;
        err_seen_d = 1'b0;
      end
      ACTIVE: begin
        if (vblank) begin
          state_d     = VBLANK;
          vdisp_d     = v_lines;
          prev_h_d    = h0_q;
          prev_t_d    = htot_q;
          prev_v_d    = v_lines;
          have_prev_d = 1'b1;
          // A frame that already reported an error never counts towards lock
          if (err_seen_q) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end else if (same_geom) begin
            lock_cnt_d = lock_inc;
            locked_d   = (lock_inc == LOCK_N);
          end else begin
            lock_cnt_d = 4'd1;
            locked_d   = 1'b0;
            fmt_err_d  = have_prev_q;
          end
        end else begin
          if (de_q) begin
            valid_d = 1'b1;
            eol_d   = ~lcd_de;
            data_d  = rgb_q;
            if (rise) begin
              x_d    = '0;
              y_d    = sat_inc(y_q);
              htot_d = per_q;
            end else begin
              x_d = sat_inc(x_q);
            end
          end
          if (fall) begin
            hdisp_d = run;
            if (!h0_set_q) begin
              h0_d     = run;
              h0_set_d = 1'b1;
            end else begin
              mismatch = (run != h0_q);
            end
          end
          sat_hit = (x_d == CMAX && x_q != CMAX) || (y_d == CMAX && y_q != CMAX) ||
                    (per_d == CMAX && per_q != CMAX);
          if (mismatch || sat_hit) begin
            fmt_err_d  = ~err_seen_q;
            err_seen_d = 1'b1;
            locked_d   = 1'b0;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      state_q     <= SEARCH;
      de_q        <= 1'b0;
      de_p_q      <= 1'b0;
      rgb_q       <= '0;
      low_q       <= '0;
      per_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      h0_q        <= '0;
      h0_set_q    <= 1'b0;
      hdisp_q     <= '0;
      htot_q      <= '0;
      vdisp_q     <= '0;
      prev_h_q    <= '0;
      prev_t_q    <= '0;
      prev_v_q    <= '0;
      have_prev_q <= 1'b0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_seen_q  <= 1'b0;
      fmt_err_q   <= 1'b0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      de_q        <= lcd_de;
      de_p_q      <= de_q;
      rgb_q       <= lcd_rgb;
      low_q       <= low_d;
      per_q       <= per_d;
      x_q         <= x_d;
      y_q         <= y_d;
      h0_q        <= h0_d;
      h0_set_q    <= h0_set_d;
      hdisp_q     <= hdisp_d;
      htot_q      <= htot_d;
      vdisp_q     <= vdisp_d;
      prev_h_q    <= prev_h_d;
      prev_t_q    <= prev_t_d;
      prev_v_q    <= prev_v_d;
      have_prev_q <= have_prev_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      err_seen_q  <= err_seen_d;
      fmt_err_q   <= fmt_err_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      data_q      <= data_d;
    end
  end

  assign pix_valid    = valid_q;
  assign pix_data     = data_q;
  assign pix_x        = x_q;
  assign pix_y        = y_q;
  assign sof          = sof_q;
  assign eol          = eol_q;
  assign h_disp_meas  = hdisp_q;
  assign h_total_meas = htot_q;
  assign v_disp_meas  = vdisp_q;
  assign locked       = locked_q;
  assign fmt_err      = fmt_err_q;
endmodule

// File: tb/tb_lcd_de_receiver.sv
// Drives DE-mode frames of several geometries and checks every output pixel and the
// per-frame measurements against a frame-level reference model.
module tb_lcd_de_receiver;
  logic        lcd_pclk = 1'b0;
  logic        rst;
  logic        lcd_de;
  logic [23:0] lcd_rgb;
  logic        pix_valid, sof, eol, locked, fmt_err;
  logic [23:0] pix_data;
  logic [10:0] pix_x, pix_y, h_disp_meas, h_total_meas, v_disp_meas;

  lcd_de_receiver #(.LOCK_FRAMES(2), .VBLANK_MIN(100)) dut (
    .lcd_pclk(lcd_pclk), .rst(rst), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eol(eol), .h_disp_meas(h_disp_meas), .h_total_meas(h_total_meas),
    .v_disp_meas(v_disp_meas), .locked(locked), .fmt_err(fmt_err)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
    logic        eol;
    logic [23:0] d;
  } pix_t;

  pix_t        exp_q[$];
  pix_t        mon_e;
  int unsigned n_chk = 0, n_fail = 0, err_cnt = 0;

  // frame-level model state
  int m_have = 0, m_ph = 0, m_pt = 0, m_pv = 0, m_cnt = 0, m_locked = 0;
  int m_ht = 0, m_hd = 0, m_vd = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_ph = 0; m_pt = 0; m_pv = 0; m_cnt = 0; m_locked = 0;
    m_ht = 0; m_hd = 0; m_vd = 0;
  endtask

  always @(negedge lcd_pclk) begin
    if (!rst) begin
      if (fmt_err) err_cnt++;
      if (pix_valid) begin
        check_eq("pix_expected", 32'(pix_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("pix_x", pix_x, mon_e.x);
          check_eq("pix_y", pix_y, mon_e.y);
          check_eq("sof", sof, mon_e.sof);
          check_eq("eol", eol, mon_e.eol);
          check_eq("pix_data", pix_data, mon_e.d);
        end
      end else begin
        check_eq("idle_out", {pix_data, sof, eol}, 0);
      end
    end
  end

  task automatic drive(input logic de, input logic [23:0] rgb);
    @(posedge lcd_pclk);
    #2;
    lcd_de  = de;
    lcd_rgb = rgb;
  endtask

  task automatic send_frame(input int hd, input int ht, input int vd, input int blank,
                            input bit pat, input int short_line, input int rst_line);
    bit          cap = 1'b1;
    int          len, m_h0, m_err, same, exp_e;
    int unsigned base;
    logic [23:0] rgb;
    pix_t        e;
    base = err_cnt;
    for (int l = 0; l < vd; l++) begin
      len = (l == short_line) ? hd - 1 : hd;
      for (int c = 0; c < ht; c++) begin
        if (c < len) begin
          rgb = pat ? {8'(l), 8'(c), 8'hA5} : 24'($urandom);
          drive(1'b1, rgb);
          if (cap) begin
            e.x   = 11'((c > 2047) ? 2047 : c);
            e.y   = 11'(l);
            e.sof = (l == 0 && c == 0);
            e.eol = (c == len - 1);
            e.d   = rgb;
            exp_q.push_back(e);
          end
        end else begin
          drive(1'b0, 24'($urandom));
          if (l == rst_line && c == len + 3) begin
            check_eq("q_empty_pre_rst", exp_q.size(), 0);
            rst = 1'b1;
          end
          if (l == rst_line && c == len + 6) begin
            rst  = 1'b0;
            cap  = 1'b0;
            base = err_cnt;
            model_reset();
          end
        end
      end
    end
    for (int i = 0; i < blank; i++) drive(1'b0, 24'($urandom));

    if (cap) begin
      m_h0  = (hd > 2047) ? 2047 : hd;
      len   = (vd - 1 == short_line) ? hd - 1 : hd;
      m_hd  = (len > 2047) ? 2047 : len;
      m_vd  = vd;
      if (vd > 1) m_ht = ht;
      m_err = ((short_line >= 0 && short_line < vd) || hd >= 2047) ? 1 : 0;
      same  = (m_have != 0 && m_h0 == m_ph && m_ht == m_pt && vd == m_pv) ? 1 : 0;
      exp_e = (m_err != 0 || (m_have != 0 && same == 0)) ? 1 : 0;
      if (m_err != 0) begin
        m_cnt = 0; m_locked = 0;
      end else if (same != 0) begin
        m_cnt    = (m_cnt >= 2) ? 2 : m_cnt + 1;
        m_locked = (m_cnt == 2) ? 1 : 0;
      end else begin
        m_cnt = 1; m_locked = 0;
      end
      m_have = 1; m_ph = m_h0; m_pt = m_ht; m_pv = vd;
    end else begin
      exp_e = 0;
    end
    check_eq("h_disp_meas", h_disp_meas, m_hd);
    check_eq("h_total_meas", h_total_meas, m_ht);
    check_eq("v_disp_meas", v_disp_meas, m_vd);
    check_eq("locked", locked, m_locked);
    check_eq("fmt_err_pulses", err_cnt - base, exp_e);
    check_eq("q_empty", exp_q.size(), 0);
  endtask

  int rht, rhd, rvd;

  initial begin
    rst     = 1'b1;
    lcd_de  = 1'b0;
    lcd_rgb = '0;
    repeat (3) @(posedge lcd_pclk);
    #1;
    check_eq("rst_flags", {pix_valid, sof, eol, locked, fmt_err}, 0);
    check_eq("rst_data", pix_data, 0);
    check_eq("rst_xy", {pix_x, pix_y}, 0);
    check_eq("rst_meas", {h_disp_meas, h_total_meas, v_disp_meas}, 0);
    @(posedge lcd_pclk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 300; i++) drive(1'b0, '0);

    for (int f = 0; f < 3; f++) send_frame(48, 60, 10, 240, 1'b1, -1, -1);
    send_frame(48, 60, 10, 240, 1'b1, -1, 4);
    for (int f = 0; f < 2; f++) send_frame(48, 60, 10, 240, 1'b1, -1, -1);
    for (int f = 0; f < 3; f++) send_frame(80, 100, 16, 400, 1'b0, -1, -1);

    rht = int'($urandom_range(100, 80));
    rhd = rht - int'($urandom_range(15, 5));
    rvd = int'($urandom_range(8, 3));
    for (int f = 0; f < 2; f++) send_frame(rhd, rht, rvd, 4 * rht, 1'b1, -1, -1);

    for (int f = 0; f < 2; f++) send_frame(48, 60, 10, 240, 1'b1, -1, -1);
    send_frame(48, 60, 10, 240, 1'b1, 2, -1);
    for (int f = 0; f < 2; f++) send_frame(48, 60, 10, 240, 1'b1, -1, -1);
    send_frame(2100, 2112, 1, 300, 1'b0, -1, -1);
    for (int f = 0; f < 2; f++) send_frame(48, 60, 10, 240, 1'b0, -1, -1);
    for (int f = 0; f < 2; f++) send_frame(1, 8, 6, 200, 1'b1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
